// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - uart_state_t  : frame FSM state encodings (IDLE/START/DATA/PARITY/STOP)
//   - UART_DATA_BITS: data bits per frame
//   - ticks_per_bit : clocks per bit period (integer divide)
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3,
      ST_PARITY = 3'd4
   } uart_state_t;

   // Clocks per bit period; the result must be >= 2 for the tick counter to be meaningful.
   function automatic int ticks_per_bit(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte push interface between the CPU-side UART logic and uart_tx.
//   in_data  : byte offered by the producer
//   in_valid : producer offers in_data this cycle
//   in_ready : consumer can accept
// Handshake: a byte transfers on the rising clock edge where in_valid && in_ready
// are both high. The producer keeps in_valid and in_data stable until that edge;
// in_ready does not depend on in_valid.
interface uart_tx_if;
   import uart_pkg::*;

   logic [UART_DATA_BITS-1:0] in_data;
   logic                      in_valid;
   logic                      in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO holding bytes waiting to be transmitted.
//   clk, rst  : clock, asynchronous active-high reset (empties the FIFO)
//   push      : write push_data (ignored when full)
//   push_data : entry to write
//   pop       : advance the read pointer (ignored when empty)
//   pop_data  : current head entry (valid while !empty)
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : number of stored entries
// DEPTH must be a power of 2 so the pointers wrap naturally.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = UART_DATA_BITS
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         // Push and pop together leave the count unchanged.
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only read after being written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count_q == (AW+1)'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with a byte FIFO. Serialises each byte as 8N1
// (start, 8 data bits LSB first, stop) at TICKS_PER_BIT clocks per bit.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset; aborts any frame, empties the FIFO
//   bus       : uart_tx_if slave (in_data / in_valid / in_ready byte push)
//   busy      : FIFO non-empty or a frame on the line
//   tx        : serial line, idle high, registered
//   state_dbg : current frame FSM state
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit between
// the last data bit and the stop bit (11-bit frames).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   uart_tx_if.slave    bus,
   output logic        busy,
   output logic        tx,
   output uart_state_t state_dbg
);

   localparam int TICKS_PER_BIT = ticks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int TW            = $clog2(TICKS_PER_BIT);

   uart_state_t               state_q, state_d;
   logic [TW-1:0]             tick_q, tick_d;
   logic [2:0]                bit_q, bit_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      tx_q, tx_d;
   logic                      pop;
   logic                      tick_end;
`ifdef UART_TX_PARITY_EN
   logic                      par_q, par_d;
`endif

   logic [UART_DATA_BITS-1:0] head;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (bus.in_valid),
      .push_data (bus.in_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign bus.in_ready = !fifo_full;
   assign tick_end     = (tick_q == TW'(TICKS_PER_BIT - 1));

   // Next-state logic. tx_d is the line level for the following cycle, so tx
   // changes exactly on the edge where the FSM changes bit period.
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            tick_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               state_d = ST_START;
`ifdef UART_TX_PARITY_EN
               par_d   = ^head;
`endif
            end
         end
         ST_START: begin
            if (tick_end) begin
               tick_d  = '0;
               tx_d    = shift_q[0];
               bit_d   = 3'd0;
               state_d = ST_DATA;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (tick_end) begin
               tick_d = '0;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = par_q;
                  state_d = ST_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
`endif
               end else begin
                  // The next line bit is the one that becomes shift[0] after the shift.
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick_end) begin
               tick_d  = '0;
               tx_d    = 1'b1;
               state_d = ST_STOP;
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (tick_end) begin
               tick_d = '0;
               // A queued byte starts straight away, with no idle cycle between frames.
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = ST_START;
`ifdef UART_TX_PARITY_EN
                  par_d   = ^head;
`endif
               end else begin
                  tx_d    = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               tick_d = tick_q + 1'b1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            tick_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx        = tx_q;
   assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);
   assign state_dbg = state_q;

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter with a small byte FIFO. It is the transmit counterpart of the SoC's existing UART receiver and drives the uart_tx pin. The CPU-side memory-mapped UART logic pushes bytes through a valid/ready handshake. The block serialises each byte as 8N1 (start, 8 data bits LSB-first, stop) at CLK_FREQ/BAUD_RATE clocks per bit.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, line rate in bit/s; TICKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide, must be >= 2)
FIFO_DEPTH, 4, byte entries in transmit FIFO; power of 2, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active high
in_data  in  8  byte to transmit
in_valid  in  1  producer offers in_data this cycle
in_ready  out  1  FIFO can accept; transfer occurs on rising edge when in_valid && in_ready
busy  out  1  high while FIFO non-empty or a frame is on the line
tx  out  1  serial line, idle high; registered output

Behaviour:
- Reset (async, rst=1): tx=1, busy=0, in_ready=1, FIFO emptied, FSM=IDLE, bit and tick counters 0. Deassertion takes effect at the next rising edge.
- in_ready = (FIFO count != FIFO_DEPTH), derived from registered count. Write when full is ignored; producer must hold in_valid.
- FIFO: read/write pointers of log2(FIFO_DEPTH) bits with natural wrap; count of log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pop from empty never happens, because the FSM only pops when count != 0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count != 0, pop the head into an 8-bit shift register, set tx=0, tick=0, go to START. Otherwise tx=1.
  - START: hold tx=0 for TICKS_PER_BIT cycles, then tx=shift[0], bit=0, go to DATA.
  - DATA: each bit held TICKS_PER_BIT cycles. At the end of the bit period, shift right, bit+1. After bit 7 completes, tx=1 and go to STOP.
  - STOP: hold tx=1 for TICKS_PER_BIT cycles. At the end, if count != 0, pop and go directly to START with tx=0 (no idle gap). Otherwise go to IDLE.
- Latency: a byte written at edge N into an empty FIFO with FSM idle is popped at edge N+1, so tx falls at edge N+1.
- Frame length: exactly 10*TICKS_PER_BIT cycles from tx falling to the end of the stop bit.
- Tick counter: width clog2(TICKS_PER_BIT); counts 0..TICKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- busy = (FSM != IDLE) || (count != 0); registered, or combinational from registered state, with no glitches on tx.
- Reset mid-frame: frame is aborted immediately, tx=1, queued bytes are discarded.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a state PARITY is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for TICKS_PER_BIT cycles. Frame length becomes 11*TICKS_PER_BIT.
- Undefined: no PARITY state, no parity logic, 8N1 only.

Decomposition:
- Shared package/include (uart_pkg): FSM state encodings (IDLE/START/DATA/STOP/PARITY), UART_DATA_BITS=8, and the TICKS_PER_BIT computation. The existing receiver shares the same package.
- One sub-module, uart_tx_fifo: parameterised synchronous FIFO (push/pop/full/empty/count). The top holds the FSM, counters and shift register.

Test Plan (CLK_FREQ=50_000_000, BAUD_RATE=25_000_000, so TICKS_PER_BIT=2; FIFO_DEPTH=4):
- Reset values: hold rst 2 cycles, release -> tx=1, busy=0, in_ready=1; tx stays 1 for 20 idle cycles.
- Single byte 0x55 written at edge N -> tx falls at edge N+1; line reads 0, then 1,0,1,0,1,0,1,0, then 1, each held 2 cycles. busy drops after 20 cycles.
- Loopback: tx wired to the SoC receiver's uart_rx, CPU program loads the received byte into x11 -> regs.mem[11]==8'h55 after the frame.
- Back-to-back: write 0x55 then 0xA3 on consecutive cycles -> 40 contiguous frame cycles, second start bit immediately after first stop bit. 0xA3 data bits are 1,1,0,0,0,1,0,1.
- FIFO full: hold in_valid with 6 distinct bytes while transmitting -> in_ready drops once 4 entries are queued. No byte is lost or duplicated; all 6 appear on tx in order.
- Reset mid-frame: assert rst during DATA bit 3 of 0x0F with 2 bytes queued -> tx=1 asynchronously, busy=0, no further frames.
- UART_TX_PARITY_EN defined: send 0x07 -> parity bit 1 before stop, frame 22 cycles. Send 0x03 -> parity bit 0.
